// File: rtl/inst_cache_pkg.sv
// inst_cache_pkg: shared state encoding and address helpers
// for the direct-mapped instruction cache.
package inst_cache_pkg;

   typedef enum logic [4:0] {
      S_IDLE   = 5'b00001,
      S_LOOKUP = 5'b00010,
      S_MISS   = 5'b00100,
      S_REFILL = 5'b01000,
      S_RESP   = 5'b10000
   } state_e;

   function automatic int off_w(input int line_words);
      return 2 + $clog2(line_words);
   endfunction

   function automatic int idx_w(input int num_sets);
      return $clog2(num_sets);
   endfunction

   function automatic int tag_w(input int line_words,
                                input int num_sets);
      return 32 - off_w(line_words) - idx_w(num_sets);
   endfunction

   function automatic logic [31:0] addr_off(
      input logic [31:0] a,
      input int          line_words
   );
      return (a >> 2) & 32'(line_words - 1);
   endfunction

   function automatic logic [31:0] addr_idx(
      input logic [31:0] a,
      input int          line_words,
      input int          num_sets
   );
      return (a >> off_w(line_words)) & 32'(num_sets - 1);
   endfunction

   function automatic logic [31:0] addr_tag(
      input logic [31:0] a,
      input int          line_words,
      input int          num_sets
   );
      return a >> (off_w(line_words) + idx_w(num_sets));
   endfunction

endpackage

// File: rtl/inst_cache_if.sv
// inst_cache_if: core fetch channel and memory refill channel
// bundled; slave is the cache side, master the environment side.
interface inst_cache_if;

   logic [31:0] cpu_req_addr;
   logic        cpu_req_valid;
   logic        cpu_req_ready;
   logic [31:0] cpu_inst;
   logic        cpu_inst_valid;
   logic        cpu_inst_ready;
   logic [31:0] mem_req_addr;
   logic        mem_req_valid;
   logic        mem_req_ready;
   logic [31:0] mem_rdata;
   logic        mem_rdata_valid;
   logic        mem_rdata_ready;

   modport slave (
      input  cpu_req_addr,
      input  cpu_req_valid,
      output cpu_req_ready,
      output cpu_inst,
      output cpu_inst_valid,
      input  cpu_inst_ready,
      output mem_req_addr,
      output mem_req_valid,
      input  mem_req_ready,
      input  mem_rdata,
      input  mem_rdata_valid,
      output mem_rdata_ready
   );

   modport master (
      output cpu_req_addr,
      output cpu_req_valid,
      input  cpu_req_ready,
      input  cpu_inst,
      input  cpu_inst_valid,
      output cpu_inst_ready,
      input  mem_req_addr,
      input  mem_req_valid,
      output mem_req_ready,
      output mem_rdata,
      output mem_rdata_valid,
      input  mem_rdata_ready
   );

endinterface

// File: rtl/inst_cache_store.sv
// inst_cache_store: valid, tag and data arrays with one
// synchronous write port and a combinational read port.
module inst_cache_store
   import inst_cache_pkg::*;
#(
   parameter  int LINE_WORDS = 8,
   parameter  int NUM_SETS   = 16,
   localparam int IDX        = idx_w(NUM_SETS),
   localparam int WW         = $clog2(LINE_WORDS),
   localparam int TAG        = tag_w(LINE_WORDS, NUM_SETS)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           data_we_i,
   input  logic           tag_we_i,
   input  logic [IDX-1:0] w_idx_i,
   input  logic [WW-1:0]  w_word_i,
   input  logic [31:0]    w_data_i,
   input  logic [TAG-1:0] w_tag_i,
   input  logic [IDX-1:0] r_idx_i,
   input  logic [WW-1:0]  r_word_i,
   output logic           r_valid_o,
   output logic [TAG-1:0] r_tag_o,
   output logic [31:0]    r_data_o
);

   logic [NUM_SETS-1:0] valid_q;
   logic [TAG-1:0]      tag_q  [NUM_SETS];
   logic [31:0]         data_q [NUM_SETS][LINE_WORDS];

   // Valid bits: all cleared on reset, one set as its refill completes
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
      end else if (tag_we_i) begin
         valid_q[w_idx_i] <= 1'b1;
      end
   end

   // Tag and data arrays: written only by refill beats, never reset
   always_ff @(posedge clk) begin
      if (data_we_i) begin
         data_q[w_idx_i][w_word_i] <= w_data_i;
      end
      if (tag_we_i) begin
         tag_q[w_idx_i] <= w_tag_i;
      end
   end

   assign r_valid_o = valid_q[r_idx_i];
   assign r_tag_o   = tag_q[r_idx_i];
   assign r_data_o  = data_q[r_idx_i][r_word_i];

endmodule

// File: rtl/inst_cache.sv
// inst_cache: direct-mapped read-only instruction cache with
// blocking line refill and hit/miss counters.
module inst_cache
   import inst_cache_pkg::*;
#(
   parameter int LINE_WORDS = 8,
   parameter int NUM_SETS   = 16
) (
   input  logic        clk,
   input  logic        rst,
   inst_cache_if.slave bus,
   output logic [31:0] hit_cnt,
   output logic [31:0] miss_cnt
);

   localparam int OFF = off_w(LINE_WORDS);
   localparam int IDX = idx_w(NUM_SETS);
   localparam int WW  = $clog2(LINE_WORDS);
   localparam int TAG = tag_w(LINE_WORDS, NUM_SETS);
   localparam logic [WW-1:0] LAST_BEAT = WW'(LINE_WORDS - 1);

   state_e         state_q, state_d;
   logic [31:0]    addr_q, addr_d;
   logic [WW-1:0]  beat_q, beat_d;
   logic [31:0]    hit_cnt_q, hit_cnt_d;
   logic [31:0]    miss_cnt_q, miss_cnt_d;

   logic [IDX-1:0] idx;
   logic [WW-1:0]  off;
   logic [TAG-1:0] tag;
   logic           r_valid;
   logic [TAG-1:0] r_tag;
   logic [31:0]    r_data;
   logic           hit;
   logic           beat_we;
   logic           last_we;

   assign idx = IDX'(addr_idx(addr_q, LINE_WORDS, NUM_SETS));
   assign off = WW'(addr_off(addr_q, LINE_WORDS));
   assign tag = TAG'(addr_tag(addr_q, LINE_WORDS, NUM_SETS));

   assign hit     = r_valid && (r_tag == tag);
   assign beat_we = (state_q == S_REFILL) && bus.mem_rdata_valid;
   assign last_we = beat_we && (beat_q == LAST_BEAT);

   inst_cache_store #(
      .LINE_WORDS (LINE_WORDS),
      .NUM_SETS   (NUM_SETS)
   ) u_store (
      .clk       (clk),
      .rst       (rst),
      .data_we_i (beat_we),
      .tag_we_i  (last_we),
      .w_idx_i   (idx),
      .w_word_i  (beat_q),
      .w_data_i  (bus.mem_rdata),
      .w_tag_i   (tag),
      .r_idx_i   (idx),
      .r_word_i  (off),
      .r_valid_o (r_valid),
      .r_tag_o   (r_tag),
      .r_data_o  (r_data)
   );

   assign bus.cpu_req_ready   = (state_q == S_IDLE);
   assign bus.cpu_inst_valid  = (state_q == S_RESP);
   assign bus.cpu_inst        = r_data;
   assign bus.mem_req_valid   = (state_q == S_MISS);
   assign bus.mem_req_addr    = {addr_q[31:OFF], {OFF{1'b0}}};
   assign bus.mem_rdata_ready = (state_q == S_REFILL);

   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;

   // Next state, address latch, beat counter and counter updates
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      beat_d     = beat_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (bus.cpu_req_valid) begin
               addr_d  = bus.cpu_req_addr;
               state_d = S_LOOKUP;
            end
         end
         S_LOOKUP: begin
            if (hit) begin
               hit_cnt_d = hit_cnt_q + 32'd1;
               state_d   = S_RESP;
            end else begin
               miss_cnt_d = miss_cnt_q + 32'd1;
               state_d    = S_MISS;
            end
         end
         S_MISS: begin
            if (bus.mem_req_ready) begin
               state_d = S_REFILL;
            end
         end
         S_REFILL: begin
            if (bus.mem_rdata_valid) begin
               beat_d = beat_q + WW'(1);
               if (beat_q == LAST_BEAT) begin
                  beat_d  = '0;
                  state_d = S_RESP;
               end
            end
         end
         S_RESP: begin
            if (bus.cpu_inst_ready) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers, synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         beat_q     <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         beat_q     <= beat_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

endmodule

// File: tb/tb_inst_cache.sv
// tb_inst_cache: randomized fetches against a set/tag model,
// with a memory responder and a decoupled response monitor.
module tb_inst_cache;

   localparam int LW = 8;
   localparam int NS = 16;
   localparam int LB = 4 * LW;

   typedef struct {
      logic [31:0] inst;
      bit          hit;
      int unsigned acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] hit_cnt;
   logic [31:0] miss_cnt;

   inst_cache_if bus ();

   inst_cache #(
      .LINE_WORDS (LW),
      .NUM_SETS   (NS)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .hit_cnt  (hit_cnt),
      .miss_cnt (miss_cnt)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          n_chk = 0;
   int          n_fail = 0;
   exp_t        sb_q[$];
   logic [31:0] memq[$];
   bit          mv   [NS];
   logic [31:0] mtag [NS];
   logic [31:0] m_hit = 0;
   logic [31:0] m_miss = 0;

   int          mem_wait = 0;
   int          gap_pct = 0;
   int          beats_acc = 0;
   int          last_wait = 0;
   int          refill_cyc = 0;
   int          resp_cnt = 0;
   int unsigned last_lat = 0;
   logic [31:0] last_inst = 0;
   logic [31:0] last_mem_addr = 0;

   task automatic chk(input string name,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic flag(input string name, input string msg);
      n_chk++;
      n_fail++;
      $display("FAIL %s: %s", name, msg);
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (32'h1000_0000 + (a >> 2)) ^ {a[31:20], 20'h0};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < NS; i++) mv[i] = 1'b0;
      m_hit  = 0;
      m_miss = 0;
      sb_q.delete();
      memq.delete();
   endtask

   // memory responder: wait states, then LW beats with random gaps
   initial begin
      int          ph;
      int          wcnt;
      int          beat;
      logic [31:0] raddr;
      ph = 0; wcnt = 0; beat = 0; raddr = 0;
      bus.mem_req_ready   = 1'b0;
      bus.mem_rdata_valid = 1'b0;
      bus.mem_rdata       = 32'h0;
      forever begin
         @(negedge clk);
         #1;
         if (rst) begin
            ph = 0;
            beat = 0;
            beats_acc = 0;
            bus.mem_req_ready   = 1'b0;
            bus.mem_rdata_valid = 1'b0;
            continue;
         end
         case (ph)
            0: begin
               if (bus.mem_req_valid) begin
                  raddr = bus.mem_req_addr;
                  last_mem_addr = raddr;
                  if (memq.size() == 0)
                     flag("mem_req", $sformatf(
                        "unexpected request %h", raddr));
                  else
                     chk("mem_req_addr", raddr, memq.pop_front());
                  wcnt = mem_wait;
                  last_wait = mem_wait;
                  refill_cyc = 0;
                  beats_acc = 0;
                  bus.mem_req_ready = (wcnt == 0);
                  ph = (wcnt == 0) ? 2 : 1;
               end
            end
            1: begin
               chk("mem_req_valid hold",
                   32'(bus.mem_req_valid), 32'd1);
               chk("mem_req_addr hold", bus.mem_req_addr, raddr);
               wcnt--;
               if (wcnt == 0) begin
                  bus.mem_req_ready = 1'b1;
                  ph = 2;
               end
            end
            2: begin
               bus.mem_req_ready = 1'b0;
               chk("mem_req_valid drop",
                   32'(bus.mem_req_valid), 32'd0);
               chk("mem_rdata_ready",
                   32'(bus.mem_rdata_ready), 32'd1);
               beat = 0;
               ph = 3;
            end
            default: begin
               if (bus.mem_rdata_valid) begin
                  beat++;
                  beats_acc = beat;
               end
            end
         endcase
         if (ph == 3) begin
            if (beat == LW) begin
               bus.mem_rdata_valid = 1'b0;
               ph = 0;
            end else begin
               refill_cyc++;
               if ($urandom_range(99) < 32'(gap_pct)) begin
                  bus.mem_rdata_valid = 1'b0;
                  bus.mem_rdata = $urandom;
               end else begin
                  bus.mem_rdata_valid = 1'b1;
                  bus.mem_rdata = mem_word(raddr + 32'(4 * beat));
               end
            end
         end
      end
   end

   // response monitor: latency, stability and data vs scoreboard
   initial begin
      bit          seen;
      bit          stall;
      logic [31:0] prev;
      int unsigned lat;
      int unsigned exp_lat;
      seen = 0; stall = 0; prev = 0;
      forever begin
         @(negedge clk);
         #2;
         if (rst) begin
            seen = 0;
            stall = 0;
            continue;
         end
         if (!bus.cpu_inst_valid) begin
            if (stall) flag("cpu_inst_valid", "dropped before ready");
            stall = 0;
            seen = 0;
         end else if (sb_q.size() == 0) begin
            if (!seen) flag("cpu_inst_valid", "response with none pending");
            seen = 1;
         end else begin
            if (!seen) begin
               lat = cyc - sb_q[0].acc + 1;
               exp_lat = sb_q[0].hit ? 2 :
                         32'(3 + last_wait + refill_cyc);
               chk("latency", lat, exp_lat);
               last_lat = lat;
               seen = 1;
            end
            if (stall) chk("cpu_inst hold", bus.cpu_inst, prev);
            if (bus.cpu_inst_ready) begin
               chk("cpu_inst", bus.cpu_inst, sb_q[0].inst);
               last_inst = bus.cpu_inst;
               void'(sb_q.pop_front());
               resp_cnt++;
               stall = 0;
               seen = 0;
            end else begin
               stall = 1;
               prev = bus.cpu_inst;
            end
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      bus.cpu_req_valid = 1'b0;
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      chk("rst cpu_req_ready", 32'(bus.cpu_req_ready), 32'd1);
      chk("rst cpu_inst_valid", 32'(bus.cpu_inst_valid), 32'd0);
      chk("rst mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("rst mem_rdata_ready", 32'(bus.mem_rdata_ready), 32'd0);
      chk("rst hit_cnt", hit_cnt, 32'd0);
      chk("rst miss_cnt", miss_cnt, 32'd0);
   endtask

   // issue one fetch; abort >= 0 stops after that many beats
   task automatic fetch(input logic [31:0] a, input int w,
                        input int gap, input int hold,
                        input int abort);
      exp_t        e;
      int          idx;
      logic [31:0] tg;
      int          bud;
      int          target;
      mem_wait = w;
      gap_pct = gap;
      bud = 0;
      @(negedge clk);
      while (!bus.cpu_req_ready && bud < 50) begin
         @(negedge clk);
         bud++;
      end
      if (!bus.cpu_req_ready) begin
         flag("cpu_req_ready", "timeout waiting for idle");
         do_reset();
      end
      idx = int'((a / LB) % NS);
      tg = a / (LB * NS);
      if (mv[idx] && mtag[idx] == tg) begin
         m_hit++;
         e.hit = 1;
      end else begin
         m_miss++;
         e.hit = 0;
         mv[idx] = 1'b1;
         mtag[idx] = tg;
         memq.push_back((a / LB) * LB);
      end
      e.inst = mem_word(a & ~32'h3);
      beats_acc = 0;
      target = resp_cnt + 1;
      bus.cpu_req_addr = a;
      bus.cpu_req_valid = 1'b1;
      bus.cpu_inst_ready = (hold == 0);
      @(negedge clk);
      e.acc = cyc;
      sb_q.push_back(e);
      bus.cpu_req_valid = 1'b0;
      bus.cpu_req_addr = $urandom;
      chk("cpu_req_ready busy", 32'(bus.cpu_req_ready), 32'd0);
      bud = 0;
      while (resp_cnt < target && bud < 300) begin
         if (abort >= 0 && beats_acc >= abort) return;
         @(negedge clk);
         bud++;
         if (bus.cpu_inst_valid && hold > 0) begin
            bus.cpu_inst_ready = 1'b0;
            hold--;
         end else begin
            bus.cpu_inst_ready = 1'b1;
         end
      end
      if (resp_cnt < target) begin
         flag("response", $sformatf("timeout for addr %h", a));
         do_reset();
         return;
      end
      chk("hit_cnt", hit_cnt, m_hit);
      chk("miss_cnt", miss_cnt, m_miss);
      chk("mem_req outstanding", 32'(memq.size()), 32'd0);
   endtask

   initial begin
      logic [31:0] saved;
      logic [31:0] base;
      bus.cpu_req_valid = 1'b0;
      bus.cpu_req_addr = 32'h0;
      bus.cpu_inst_ready = 1'b1;
      model_clear();
      repeat (3) @(negedge clk);
      chk("reset cpu_req_ready", 32'(bus.cpu_req_ready), 32'd1);
      chk("reset cpu_inst_valid", 32'(bus.cpu_inst_valid), 32'd0);
      chk("reset mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
      chk("reset mem_rdata_ready", 32'(bus.mem_rdata_ready), 32'd0);
      chk("reset hit_cnt", hit_cnt, 32'd0);
      chk("reset miss_cnt", miss_cnt, 32'd0);
      rst = 1'b0;

      fetch(32'h0000_0010, 0, 0, 0, -1);
      chk("cold mem_req_addr", last_mem_addr, 32'h0);
      chk("cold cpu_inst", last_inst, 32'h1000_0004);
      chk("cold latency", last_lat, 32'd11);
      chk("cold miss_cnt", miss_cnt, 32'd1);

      fetch(32'h0000_001C, 0, 0, 0, -1);
      chk("hit cpu_inst", last_inst, 32'h1000_0007);
      chk("hit latency", last_lat, 32'd2);
      chk("hit hit_cnt", hit_cnt, 32'd1);

      fetch(32'h0000_0084, 5, 50, 3, -1);
      chk("bp cpu_inst", last_inst, 32'h1000_0021);

      fetch(32'h0000_0040, 0, 0, 0, 3);
      saved = last_mem_addr;
      do_reset();
      fetch(32'h0000_0040, 0, 0, 0, -1);
      chk("rerefill mem_req_addr", last_mem_addr, saved);
      chk("rerefill miss_cnt", miss_cnt, 32'd1);
      chk("rerefill cpu_inst", last_inst, 32'h1000_0010);

      base = miss_cnt;
      fetch(32'h0000_0000, 0, 0, 0, -1);
      fetch(32'h0000_0200, 1, 20, 0, -1);
      chk("conflict cpu_inst", last_inst, 32'h1000_0080);
      fetch(32'h0000_0000, 0, 0, 0, -1);
      chk("conflict misses", miss_cnt, base + 32'd3);
      chk("conflict cpu_inst", last_inst, 32'h1000_0000);

      force dut.hit_cnt_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.hit_cnt_q;
      m_hit = 32'hFFFF_FFFF;
      chk("forced hit_cnt", hit_cnt, 32'hFFFF_FFFF);
      fetch(32'h0000_0004, 0, 0, 0, -1);
      chk("wrap hit_cnt", hit_cnt, 32'd0);

      repeat (60) begin
         fetch($urandom_range(0, 32'h7FF),
               int'($urandom_range(0, 3)), 30,
               int'($urandom_range(0, 2)), -1);
      end

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_cache.md
# inst_cache

Direct-mapped, read-only instruction cache placed between the multi-cycle core's instruction request/response channels and the memory bus. It accepts one fetch address at a time and returns the 32-bit instruction word, either from its line store on a hit or after a fixed-length line refill from memory on a miss. Hit and miss counters are exported so they can drive two of the core's performance-counter outputs.

## Interface
- `LINE_WORDS`, default 8: words per line; must be a power of 2, minimum 2.
- `NUM_SETS`, default 16: number of lines; must be a power of 2, minimum 2.
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_req_addr` in 32: fetch address; bits [1:0] ignored.
- `cpu_req_valid` in 1: fetch request.
- `cpu_req_ready` out 1: cache can accept a request.
- `cpu_inst` out 32: returned instruction.
- `cpu_inst_valid` out 1: `cpu_inst` is valid.
- `cpu_inst_ready` in 1: core accepts `cpu_inst`.
- `mem_req_addr` out 32: line-aligned refill address.
- `mem_req_valid` out 1: refill request.
- `mem_req_ready` in 1: memory accepts the request.
- `mem_rdata` in 32: refill beat data.
- `mem_rdata_valid` in 1: beat valid.
- `mem_rdata_ready` out 1: cache accepts a beat.
- `hit_cnt` out 32: number of lookups that hit.
- `miss_cnt` out 32: number of lookups that missed.

## Operation
- Address split:
  - offset = addr[OFF-1:2], where OFF = 2 + log2(LINE_WORDS).
  - index = addr[OFF+IDX-1:OFF], where IDX = log2(NUM_SETS).
  - tag = addr[31:OFF+IDX].
- Per-set state: one valid bit, a tag register and LINE_WORDS data words.
- States: IDLE, LOOKUP, MISS, REFILL, RESP.
  - IDLE: `cpu_req_ready`=1. When `cpu_req_valid` is high, latch the address and go to LOOKUP.
  - LOOKUP: hit means valid[index] and the stored tag equals the address tag. On a hit, increment `hit_cnt` and go to RESP. On a miss, increment `miss_cnt` and go to MISS.
  - MISS: `mem_req_valid`=1 and `mem_req_addr` = {latched addr[31:OFF], OFF'b0}. Go to REFILL when `mem_req_ready` is high.
  - REFILL: `mem_rdata_ready`=1. Each accepted beat writes data[index][beat_cnt], and beat_cnt increments.
    - On the beat where beat_cnt = LINE_WORDS-1: write the tag, set valid[index]=1, clear beat_cnt and go to RESP.
  - RESP: `cpu_inst_valid`=1 and `cpu_inst` = data[index][offset]. When `cpu_inst_ready` is high, go to IDLE.
- Only one request can be outstanding. `cpu_req_ready`=0 in every state except IDLE.
- Beats are written in ascending word order starting at word 0. The line becomes valid only after the final beat.
- A refill overwrites the resident line even if that line was valid; there is no write-back.
- Counters are 32 bits and wrap from 0xFFFF_FFFF to 0.
- `cpu_req_addr` and the memory inputs are ignored in every state that does not sample them.

## Timing
- Reset values:
  - state IDLE; all valid bits 0; beat_cnt 0; `hit_cnt` and `miss_cnt` 0.
  - `cpu_req_ready` 1; `cpu_inst_valid`, `mem_req_valid` and `mem_rdata_ready` 0.
  - `mem_req_addr` and `cpu_inst` are don't-care while their valid signal is low.
- Reset during any state, including mid-refill, returns the block to IDLE on the next edge. The partial line is discarded and all lines are invalidated.
- Hit latency: request accepted at edge 0, `cpu_inst_valid` high after edge 2.
- Miss latency: 2 + (MISS wait cycles) + LINE_WORDS beats + 1 cycles to RESP. With zero memory wait states: LINE_WORDS + 3 cycles.
- `cpu_inst_valid` and `cpu_inst` stay stable until `cpu_inst_ready` is high. The earliest next request is accepted one cycle after the response handshake.
- `mem_req_valid` and `mem_req_addr` stay stable until `mem_req_ready` is high.
- All outputs are driven from registers or from the state register plus array reads; there are no combinational input-to-output paths except the array read mux.

## Structure
- Package `inst_cache_pkg` holds:
  - the state encoding, one-hot, 5 bits;
  - functions deriving OFF, IDX and tag width from the parameters;
  - the index/offset/tag field-extraction helpers.
- Sub-module `inst_cache_store`: the tag, valid and data arrays with a synchronous write port, a combinational read port, and a synchronous invalidate-all on `rst`. The FSM and counters live in `inst_cache`.

## Test plan
- Cold miss, zero wait states, defaults:
  - Stimulus: fetch 0x0000_0010 with memory returning beats 0x1000_0000 + i.
  - Required: `mem_req_addr` = 0x0000_0000, `cpu_inst` = 0x1000_0004, response valid 11 cycles after acceptance, `miss_cnt` = 1.
- Hit:
  - Stimulus: after the cold-miss test, fetch 0x0000_001C.
  - Required: `cpu_inst` = 0x1000_0007 valid 2 cycles after acceptance, no memory request, `hit_cnt` = 1.
- Conflict eviction:
  - Stimulus: fetch 0x0000_0000, then 0x0000_0200 (same index, different tag), then 0x0000_0000.
  - Required: three misses, and the third returns the original word re-refilled.
- Backpressure:
  - Stimulus: hold `mem_req_ready`=0 for 5 cycles, deassert `mem_rdata_valid` between beats, and hold `cpu_inst_ready`=0 for 3 cycles in RESP.
  - Required: request address stable, correct data, `cpu_inst` stable.
- Reset mid-refill:
  - Stimulus: assert `rst` after 3 of 8 beats, then fetch the same address.
  - Required: a new miss with `mem_req_addr` identical, counters at 0 then `miss_cnt` = 1.
- Counter wrap:
  - Stimulus: force `hit_cnt` to 0xFFFF_FFFF, then perform one hit.
  - Required: `hit_cnt` = 0.
